instr_loader: RTL
=================

Name: instr_loader

Overview:
- Boot-time writer for the instruction memory that the processor core fetches from.
- Receives a framed byte stream over a valid/ready byte interface and assembles little-endian 32-bit instruction words.
- Writes each word sequentially into instruction memory and verifies an XOR checksum.
- Holds the core in reset until a load completes successfully.

Parameters:
- BASE_ADDR, 0, byte address of the first instruction word written.
- MAX_WORDS, 256, largest legal word count; larger frames are rejected.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_valid  in  1  byte-stream source has a byte.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts the byte this cycle; transfer occurs when rx_valid & rx_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write, BASE_ADDR + 4*word_index.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  core reset request; low only in DONE.
- load_done  out  1  high while in DONE.
- load_error  out  1  high while in ERROR.
- words_loaded  out  16  count of words written in the current or last frame.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then 1 checksum byte.
  - Data bytes arrive least-significant byte first within each word.
  - The checksum is the XOR of all data bytes only; length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
  - Byte counter, word index and checksum accumulator are cleared.
- IDLE: start=1 → LEN_LO. At the same time, words_loaded, word index and checksum are cleared.
- rx_ready is 1 in LEN_LO, LEN_HI, DATA and CHECK. It is 0 in IDLE, DONE and ERROR. There is no other backpressure. rx_valid gaps of any length are tolerated.
- LEN_LO: accepted byte → N[7:0]; next state LEN_HI.
- LEN_HI: accepted byte → N[15:8]. Next state:
  - N > MAX_WORDS → ERROR.
  - N = 0 → CHECK.
  - otherwise → DATA.
- DATA:
  - Each accepted byte shifts into the word at byte lane 0..3 and XORs into the checksum.
  - On acceptance of lane 3, in the following cycle: mem_we=1 for exactly one cycle, mem_addr = BASE_ADDR + 4*word_index, mem_wdata = complete word.
  - word_index and words_loaded increment in the same cycle as the mem_we pulse.
  - rx_ready stays 1 during the write cycle, so a byte accepted then goes to lane 0 of the next word.
  - After the lane-3 byte of word N-1 is accepted → CHECK. The last write pulse overlaps the first CHECK cycle.
- CHECK: accepted byte equal to the checksum → DONE; any other value → ERROR. The transition happens on the edge of acceptance.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Address arithmetic is 32-bit modulo 2^32; word_index is 16 bits.
- DONE: cpu_hold=0, load_done=1. start → LEN_LO, which re-asserts cpu_hold in that cycle.
- ERROR: cpu_hold=1, load_error=1. start → LEN_LO.
  - Words already written are not rolled back.
  - words_loaded keeps the count actually written.
- start while in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- start and rx_valid in the same IDLE cycle: no byte is accepted that cycle, because rx_ready=0 in IDLE.
- Reset mid-frame: the loader returns to IDLE immediately. A pending mem_we for the next cycle is suppressed.

Test Plan:
- Basic load, BASE_ADDR=0: start, then bytes 02 00 44 33 22 11 DD CC BB AA 44.
  - Required: mem_we pulses exactly twice, (addr 0x0, data 0x11223344) and (addr 0x4, data 0xAABBCCDD).
  - Then words_loaded=2, DONE, cpu_hold=0, load_done=1.
- Bad checksum: same frame with final byte 45.
  - Required: two writes, then ERROR, load_error=1, cpu_hold=1, rx_ready=0, words_loaded=2.
- Oversize frame: bytes 2C 01 (N=300, MAX_WORDS=256).
  - Required: ERROR right after LEN_HI, no mem_we, further rx bytes not accepted.
- Zero-length frame: bytes 00 00 00 → DONE with no mem_we. Bytes 00 00 01 → ERROR.
- Stalls and restart: basic frame with rx_valid deasserted 3 cycles between every byte → identical writes and DONE. Then a second start with a 1-word frame 01 00 78 56 34 12 08 → write (0x0, 0x12345678), DONE, words_loaded=1.
- Reset mid-load: basic frame, reset=0 on the cycle the 6th byte (0x11) is accepted.
  - Required: no mem_we afterwards, IDLE, all outputs at reset values, start then required to resume.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: framed byte stream in, 32-bit
// little-endian words out, XOR-checked, core held in reset until done.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_error_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;
  logic [15:0] words_q, words_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        acc;
  logic [15:0] n_w;

  assign rx_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
  assign acc = rx_valid_i & rx_ready_o;
  assign n_w = {rx_data_i, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    chk_d   = chk_q;
    len_d   = len_q;
    widx_d  = widx_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_LO;
          words_d = '0;
          widx_d  = '0;
          chk_d   = '0;
          lane_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d[7:0] = rx_data_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d = n_w;
          if ({1'b0, n_w} > MAX_W) state_d = S_ERROR;
          else if (n_w == 16'd0)   state_d = S_CHECK;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          chk_d  = chk_q ^ rx_data_i;
          word_d = {rx_data_i, word_q[31:8]};
          lane_d = lane_q + 2'd1;
          // Lane 3 completes a word: register the write for next cycle
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, widx_q, 2'b00};
            wdata_d = word_d;
            widx_d  = widx_q + 16'd1;
            words_d = words_q + 16'd1;
            if (widx_q + 16'd1 == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (acc) state_d = (rx_data_i == chk_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      chk_q   <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      chk_q   <= chk_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign cpu_hold_o     = (state_q != S_DONE);
  assign load_done_o    = (state_q == S_DONE);
  assign load_error_o   = (state_q == S_ERROR);
  assign words_loaded_o = words_q;

endmodule
